// File: rtl/output_requant_buffer.sv
// Requantizes the convolution accumulator stream (round, shift, saturate) and buffers it in a FWFT FIFO.
// Build option: define OUTPUT_RELU_EN to clamp negative requantized results to zero.
module output_requant_buffer #(
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    input  logic                   in_valid,
    input  logic [ACC_WIDTH-1:0]   in_data,
    input  logic [31:0]            in_x,
    input  logic [31:0]            in_y,
    input  logic [31:0]            in_ch,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [31:0]            out_x,
    output logic [31:0]            out_y,
    output logic [31:0]            out_ch
);

    localparam int unsigned SUM_W = ACC_WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(1) << (SHIFT - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [31:0]          x;
        logic [31:0]          y;
        logic [31:0]          ch;
    } entry_t;

    logic signed [SUM_W-1:0] sum_ext;
    logic signed [SUM_W-1:0] shifted;
    logic [OUT_WIDTH-1:0]    sat_c;

    logic                    s1_valid;
    entry_t                  s1_entry;

    entry_t                  mem [DEPTH];
    entry_t                  head;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count_nxt;
    logic                    full_c;
    logic                    push_c;
    logic                    pop_c;
    logic                    wr_en_c;

    // Round-half-up, arithmetic shift one bit wider than the accumulator, then clamp.
    always_comb begin
        sum_ext = $signed({in_data[ACC_WIDTH-1], in_data}) + ROUND;
        shifted = sum_ext >>> SHIFT;
        if (shifted > SAT_MAX) begin
            sat_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            sat_c = shifted[OUT_WIDTH-1:0];
        end
`ifdef OUTPUT_RELU_EN
        if (sat_c[OUT_WIDTH-1]) begin
            sat_c = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_entry <= '{data: sat_c, x: in_x, y: in_y, ch: in_ch};
            end
        end
    end

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        full_c    = (count == CNT_W'(DEPTH));
        pop_c     = out_valid && out_ready;
        push_c    = s1_valid;
        wr_en_c   = push_c && (!full_c || pop_c);
        count_nxt = count;
        if (wr_en_c && !pop_c) begin
            count_nxt = count + CNT_W'(1);
        end else if (!wr_en_c && pop_c) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_nxt;
            overflow    <= overflow | (push_c && full_c && !pop_c);
            almost_full <= (count_nxt >= CNT_W'(AFULL_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n_in && wr_en_c) begin
            mem[wr_ptr] <= s1_entry;
        end
    end

    // Head falls through from storage; zeroed while empty so reset leaves all outputs at 0.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count != '0);
        out_data  = out_valid ? head.data : '0;
        out_x     = out_valid ? head.x    : '0;
        out_y     = out_valid ? head.y    : '0;
        out_ch    = out_valid ? head.ch   : '0;
    end

endmodule

// File: tb/tb_output_requant_buffer.sv
// Directed bench for output_requant_buffer: rounding, saturation, tags, backpressure, overflow, full push+pop, reset.
module tb_output_requant_buffer;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_ch;
    logic        almost_full;
    logic        overflow;
    logic [4:0]  count;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_ch;

    int tests  = 0;
    int failed = 0;

    output_requant_buffer dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_ch      (in_ch),
        .almost_full(almost_full),
        .overflow   (overflow),
        .count      (count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_ch     (out_ch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated word: push, wait the two-cycle latency, check head, pop it.
    task automatic one_word(input string tag, input logic [31:0] din, input logic [15:0] exp);
        in_valid = 1'b1;
        in_data  = din;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(count), 32'd0);
    endtask

    initial begin
        arst_n_in = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_x      = '0;
        in_y      = '0;
        in_ch     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        arst_n_in = 1'b1;
        tick();

        // Tags ride with the data word.
        in_x = 32'd3;
        in_y = 32'd5;
        in_ch = 32'd7;
        in_valid = 1'b1;
        in_data  = 32'h0000_1280;
        tick();
        in_valid = 1'b0;
        tick();
        chk("tag_data", 32'(out_data), 32'h0013);
        chk("tag_x", out_x, 32'd3);
        chk("tag_y", out_y, 32'd5);
        chk("tag_ch", out_ch, 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        one_word("round_dn", 32'h0000_127F, 16'h0012);
        one_word("sat_pos", 32'h7FFF_FFFF, 16'h7FFF);
`ifdef OUTPUT_RELU_EN
        one_word("sat_neg", 32'h8000_0000, 16'h0000);
        one_word("neg_one", 32'hFFFF_FF00, 16'h0000);
`else
        one_word("sat_neg", 32'h8000_0000, 16'h8000);
        one_word("neg_one", 32'hFFFF_FF00, 16'hFFFF);
`endif

        // Backpressure: 16 back-to-back pushes, word i carries value i and x=i.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i) << 8;
            in_x     = 32'(i);
            tick();
            if (i == 11) begin
                chk("afull_11", 32'(almost_full), 32'd0);
                chk("count_11", 32'(count), 32'd11);
            end
            if (i == 12) begin
                chk("afull_12", 32'(almost_full), 32'd1);
                chk("count_12", 32'(count), 32'd12);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'd99 << 8;
        in_x     = 32'd99;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("hold_data", 32'(out_data), 32'd0);
        tick();
        chk("hold_data2", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            chk("drain_x", out_x, 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        arst_n_in = 1'b0;
        tick();
        arst_n_in = 1'b1;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Keep the pipeline busy so the FIFO reaches 16 with stage 1 still holding a word.
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i) << 8;
            in_x     = 32'(i);
            tick();
        end
        chk("pp_full", 32'(count), 32'd16);
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            chk("pp_head", 32'(out_data), 32'(j));
            in_data = 32'(j + 17) << 8;
            in_x    = 32'(j + 17);
            tick();
            chk("pp_count", 32'(count), 32'd16);
            chk("pp_ovf", 32'(overflow), 32'd0);
        end

        // Reset mid-stream with traffic still applied.
        arst_n_in = 1'b0;
        tick();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_afull", 32'(almost_full), 32'd0);
        arst_n_in = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
